lif_neuron: RTL and testbench
=============================

# lif_neuron

Leaky integrate-and-fire neuron producing the post-synaptic spike consumed by the STDP learning block. It receives the 4-bit pre-synaptic spike vector and four 4-bit synaptic weights (the STDP block's weight output). Each cycle it accumulates the weighted input into a saturating membrane potential with shift-based leak. When the potential reaches threshold it emits a one-cycle `post_spike` pulse, then holds in a refractory period.

## Interface
- `THRESHOLD`, default 100: firing threshold; legal range 1..255.
- `LEAK_SHIFT`, default 3: leak is `v >> LEAK_SHIFT`; legal range 1..7.
- `REFRACTORY`, default 4: number of refractory cycles after the fire cycle; legal range 0..15.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous and active-high (asserted = 1).
- `en`  input  1  integrate enable; when 0, membrane and state hold.
- `pre_spike`  input  4  pre-synaptic spikes; bit i is neuron i.
- `weight_in`  input  16  packed unsigned weights; `weight_in[4i+3:4i]` belongs to pre neuron i.
- `post_spike`  output  1  registered one-cycle fire pulse.
- `membrane`  output  8  registered membrane potential, unsigned.
- `refractory`  output  1  high while in FIRE or REFRACT.
- `spike_count`  output  8  number of post spikes since reset; wraps 255->0.

## Operation
- States: INTEGRATE, FIRE, REFRACT. Reset state is INTEGRATE.
- Reset (async, while `rst_n`=1) forces the following: state INTEGRATE, `membrane`=0, `post_spike`=0, `refractory`=0, `spike_count`=0, refractory counter=0.
- INTEGRATE with `en`=1: compute the following.
  - syn = sum of `weight_in` nibbles where `pre_spike` bit is 1. syn is 6 bits, maximum 60.
  - leak = 0 if v=0. Otherwise leak = max(v >> LEAK_SHIFT, 1).
  - v_next = min(v - leak + syn, 255). Use a 9-bit intermediate; there is no underflow because leak ≤ v.
- If v_next ≥ THRESHOLD, go to FIRE: `membrane`<=0, `post_spike`<=1, `refractory`<=1, `spike_count`<=`spike_count`+1. Otherwise `membrane`<=v_next.
- INTEGRATE with `en`=0: all registers hold and `post_spike`=0.
- FIRE lasts exactly one cycle. `post_spike` is 1 during FIRE and `membrane` is 0. Inputs are ignored.
  - REFRACTORY>0: go to REFRACT and load the counter with REFRACTORY.
  - REFRACTORY=0: go to INTEGRATE.
- REFRACT: `membrane` is held at 0 and inputs are ignored. The counter decrements each cycle, independent of `en`. On the cycle it reaches 1, the next state is INTEGRATE.
- `refractory` is 1 in FIRE and REFRACT, and 0 in INTEGRATE.
- The fire decision uses the same-cycle inputs. Spikes arriving during FIRE/REFRACT are lost; they are not queued.

## Timing
- Inputs are sampled at rising edge n. `membrane` reflects them after edge n. A threshold crossing at edge n drives `post_spike` high from edge n to edge n+1.
- `post_spike` is high for exactly 1 cycle per fire. It is never high on two consecutive cycles, even with REFRACTORY=0, because FIRE is followed by at least one INTEGRATE evaluation.
- Refractory window: `refractory`=1 for 1+REFRACTORY cycles. The first input sampled again is at edge n+2+REFRACTORY.
- Reset mid-FIRE or mid-REFRACT: outputs clear immediately (asynchronously). The first integration happens at the first edge after deassertion.
- `spike_count` increments on the same edge `post_spike` rises. It wraps from 255 to 0 with no flag.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use the defaults THRESHOLD=100, LEAK_SHIFT=3, REFRACTORY=4.
- **Reset:** assert `rst_n` between edges, then hold 3 cycles.
  - Outputs are 0 immediately, before any edge, and stay 0. State is INTEGRATE.
- **Single input:** `pre_spike`=0001, weight[0]=15 every cycle, `en`=1.
  - `membrane` sequence: 15, 29, 41, 51, 60, 68, 75, 81, 86, 91, 95, 99.
  - At edge 13, `post_spike`=1, `membrane`=0, `spike_count`=1.
- **All inputs:** `pre_spike`=1111, all weights 15.
  - `membrane`=60 after edge 1. Fire at edge 2 (v_next=113).
  - `refractory`=1 for 5 cycles. Inputs are ignored until edge 7, after which `membrane`=60 again.
- **Leak floor:** load `membrane`=10, then `pre_spike`=0.
  - Decay is 9, 8, 7, ..., 1, 0 (leak clamped to 1), then holds at 0.
  - With `en`=0 at `membrane`=5, it holds at 5.
- **Async reset in REFRACT:** fire, then assert `rst_n` 2 cycles into REFRACT.
  - `refractory`, `membrane`, and `spike_count` clear at once.
  - The first edge after release integrates the inputs normally.
- **Wrap and REFRACTORY=0:** force 256 fires with REFRACTORY=0 and all inputs at weight 15.
  - `post_spike` pattern is 1,0,1,0,...
  - `spike_count` wraps to 0 on the 256th fire.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted 4-input integration with saturating
// shift leak, one-cycle fire pulse, then a fixed refractory hold.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// INTEGRATE | accumulate weighted spikes with leak (when en=1)
// FIRE      | one-cycle post_spike pulse, membrane cleared
// REFRACT   | membrane held at 0, counter runs down to 1 then back to INTEGRATE
module lif_neuron #(
    parameter int THRESHOLD  = 100,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACTORY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  pre_spike,
    input  logic [15:0] weight_in,
    output logic        post_spike,
    output logic [7:0]  membrane,
    output logic        refractory,
    output logic [7:0]  spike_count
);

    typedef enum logic [1:0] {
        S_INTEGRATE,
        S_FIRE,
        S_REFRACT
    } state_t;

    state_t     state;
    logic [3:0] refr_cnt;

    logic [5:0] syn;
    logic [7:0] leak;
    logic [8:0] v_sum;
    logic [7:0] v_next;
    logic       fire;

    always_comb begin
        syn = '0;
        for (int i = 0; i < 4; i++) begin
            if (pre_spike[i]) begin
                syn = syn + {2'b00, weight_in[4*i +: 4]};
            end
        end
        // Small nonzero potentials still decay by one so the membrane reaches 0.
        leak = membrane >> LEAK_SHIFT;
        if ((membrane != 8'd0) && (leak == 8'd0)) begin
            leak = 8'd1;
        end
        v_sum  = {1'b0, membrane} - {1'b0, leak} + {3'b000, syn};
        v_next = (v_sum > 9'd255) ? 8'hff : v_sum[7:0];
        fire   = (v_next >= 8'(THRESHOLD));
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= S_INTEGRATE;
            membrane    <= '0;
            post_spike  <= 1'b0;
            refractory  <= 1'b0;
            spike_count <= '0;
            refr_cnt    <= '0;
        end else begin
            case (state)
                S_INTEGRATE: begin
                    post_spike <= 1'b0;
                    if (en) begin
                        if (fire) begin
                            state       <= S_FIRE;
                            membrane    <= '0;
                            post_spike  <= 1'b1;
                            refractory  <= 1'b1;
                            spike_count <= spike_count + 8'd1;
                        end else begin
                            membrane <= v_next;
                        end
                    end
                end
                S_FIRE: begin
                    post_spike <= 1'b0;
                    membrane   <= '0;
                    if (REFRACTORY > 0) begin
                        state    <= S_REFRACT;
                        refr_cnt <= 4'(REFRACTORY);
                    end else begin
                        state      <= S_INTEGRATE;
                        refractory <= 1'b0;
                    end
                end
                S_REFRACT: begin
                    membrane <= '0;
                    if (refr_cnt <= 4'd1) begin
                        state      <= S_INTEGRATE;
                        refractory <= 1'b0;
                        refr_cnt   <= '0;
                    end else begin
                        refr_cnt <= refr_cnt - 4'd1;
                    end
                end
                default: begin
                    state      <= S_INTEGRATE;
                    membrane   <= '0;
                    post_spike <= 1'b0;
                    refractory <= 1'b0;
                    refr_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default instance for integrate/leak/refractory,
// second instance (REFRACTORY=0, THRESHOLD=60) for back-to-back fires and count wrap.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        en;
    logic [3:0]  pre_spike;
    logic [15:0] weight_in;

    logic        post_a, refr_a;
    logic [7:0]  mem_a, cnt_a;
    logic        post_b, refr_b;
    logic [7:0]  mem_b, cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lif_neuron dut_a (
        .clk        (clk),
        .rst_n      (rst_a),
        .en         (en),
        .pre_spike  (pre_spike),
        .weight_in  (weight_in),
        .post_spike (post_a),
        .membrane   (mem_a),
        .refractory (refr_a),
        .spike_count(cnt_a)
    );

    // Threshold 60 makes every evaluation from a cleared membrane fire (syn = 60).
    lif_neuron #(.THRESHOLD(60), .LEAK_SHIFT(3), .REFRACTORY(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_b),
        .en         (en),
        .pre_spike  (pre_spike),
        .weight_in  (weight_in),
        .post_spike (post_b),
        .membrane   (mem_b),
        .refractory (refr_b),
        .spike_count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_mem"},  32'(mem_a),  0);
        chk({tag, "_post"}, 32'(post_a), 0);
        chk({tag, "_refr"}, 32'(refr_a), 0);
        chk({tag, "_cnt"},  32'(cnt_a),  0);
    endtask

    int single_seq [12] = '{15, 29, 41, 51, 60, 68, 75, 81, 86, 91, 95, 99};

    initial begin
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        en        = 1'b0;
        pre_spike = 4'b0000;
        weight_in = 16'h0000;
        repeat (2) tick();

        // Reset: build up some state, then assert reset between edges.
        rst_a     = 1'b0;
        en        = 1'b1;
        pre_spike = 4'b0001;
        weight_in = 16'h000F;
        repeat (3) tick();
        chk("pre_reset_mem", 32'(mem_a), 41);
        #2 rst_a = 1'b1;
        #1 chk_idle_a("reset_immediate");
        repeat (3) tick();
        chk_idle_a("reset_held");

        // Single input, weight 15.
        rst_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("single_mem_%0d", i + 1), 32'(mem_a), 32'(single_seq[i]));
            chk("single_nopost", 32'(post_a), 0);
        end
        tick();
        chk("single_fire_post", 32'(post_a), 1);
        chk("single_fire_mem",  32'(mem_a),  0);
        chk("single_fire_cnt",  32'(cnt_a),  1);
        chk("single_fire_refr", 32'(refr_a), 1);
        tick();
        chk("single_after_post", 32'(post_a), 0);

        // All four inputs at weight 15.
        #2 rst_a = 1'b1;
        #1 rst_a = 1'b0;
        pre_spike = 4'b1111;
        weight_in = 16'hFFFF;
        tick();
        chk("all_mem_1", 32'(mem_a), 60);
        chk("all_refr_1", 32'(refr_a), 0);
        tick();
        chk("all_fire_post", 32'(post_a), 1);
        chk("all_fire_mem",  32'(mem_a),  0);
        chk("all_fire_cnt",  32'(cnt_a),  1);
        chk("all_fire_refr", 32'(refr_a), 1);
        for (int e = 3; e <= 6; e++) begin
            tick();
            chk($sformatf("all_refr_e%0d", e), 32'(refr_a), 1);
            chk($sformatf("all_post_e%0d", e), 32'(post_a), 0);
            chk($sformatf("all_mem_e%0d", e),  32'(mem_a),  0);
        end
        tick();
        chk("all_refr_e7", 32'(refr_a), 0);
        chk("all_mem_e7",  32'(mem_a),  0);
        tick();
        chk("all_mem_e8", 32'(mem_a), 60);
        chk("all_cnt_e8", 32'(cnt_a), 1);

        // Leak floor from 10 down to 0.
        #2 rst_a = 1'b1;
        #1 rst_a = 1'b0;
        pre_spike = 4'b0001;
        weight_in = 16'h000A;
        tick();
        chk("leak_load", 32'(mem_a), 10);
        pre_spike = 4'b0000;
        for (int v = 9; v >= 0; v--) begin
            tick();
            chk($sformatf("leak_decay_%0d", v), 32'(mem_a), 32'(v));
        end
        repeat (2) tick();
        chk("leak_hold_zero", 32'(mem_a), 0);

        // en=0 holds the membrane even with strong input present.
        pre_spike = 4'b0001;
        weight_in = 16'h0005;
        tick();
        chk("en_load", 32'(mem_a), 5);
        en        = 1'b0;
        pre_spike = 4'b1111;
        weight_in = 16'hFFFF;
        repeat (3) tick();
        chk("en_hold_mem",  32'(mem_a),  5);
        chk("en_hold_post", 32'(post_a), 0);
        en = 1'b1;

        // Async reset two cycles into REFRACT.
        #2 rst_a = 1'b1;
        #1 rst_a = 1'b0;
        tick();
        chk("ar_mem_1", 32'(mem_a), 60);
        tick();
        chk("ar_fire", 32'(post_a), 1);
        repeat (2) tick();
        chk("ar_in_refract", 32'(refr_a), 1);
        chk("ar_cnt_before", 32'(cnt_a),  1);
        #2 rst_a = 1'b1;
        #1 chk_idle_a("ar_cleared");
        #1 rst_a = 1'b0;
        tick();
        chk("ar_first_mem",  32'(mem_a),  60);
        chk("ar_first_refr", 32'(refr_a), 0);
        chk("ar_first_post", 32'(post_a), 0);

        // REFRACTORY=0: alternating fires and spike_count wrap.
        chk("wrap_reset_cnt", 32'(cnt_b), 0);
        rst_b = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk($sformatf("wrap_post_hi_%0d", k), 32'(post_b), 1);
            chk($sformatf("wrap_cnt_%0d", k), 32'(cnt_b), 32'(k % 256));
            tick();
            chk($sformatf("wrap_post_lo_%0d", k), 32'(post_b), 0);
            chk($sformatf("wrap_refr_lo_%0d", k), 32'(refr_b), 0);
        end
        chk("wrap_final_cnt", 32'(cnt_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
